// File: rtl/fft_pkg.sv
// Shared constants and fft_io state encoding for the 64-point base-8 FFT.
package fft_pkg;

  localparam int SIZE_MAT    = 8;
  localparam int SIZE_MAT_WD = 3;
  localparam int FRAME_LEN   = SIZE_MAT * SIZE_MAT;
  localparam int FRAME_WD    = 2 * SIZE_MAT_WD;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_STRT,
    ST_CALC,
    ST_DUMP,
    ST_DRAIN
  } fft_io_state_t;

endpackage

// File: rtl/fft_io_skid.sv
// Two-entry FIFO that absorbs read data in flight while downstream stalls.
module fft_io_skid #(
  parameter int DATA_WD = -1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [DATA_WD-1:0] i_dat,
  input  logic               i_pop,
  output logic               o_full,
  output logic               o_empty,
  output logic [DATA_WD-1:0] o_dat
);

  logic [DATA_WD-1:0] r_mem [2];
  logic               r_wrPtr;
  logic               r_rdPtr;
  logic [1:0]         r_cnt;
  logic               w_doPush;
  logic               w_doPop;

  assign o_full   = (r_cnt == 2'd2);
  assign o_empty  = (r_cnt == 2'd0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_dat    = o_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_cnt    <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_dat;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_doPop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_cnt <= r_cnt + {1'b0, w_doPush} - {1'b0, w_doPop};
    end
  end

  // The upstream read throttle must never let data arrive into a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(i_push && o_full));

endmodule

// File: rtl/fft_io.sv
// Sample I/O sequencer: loads 64 samples into the FFT matrix memory, kicks the
// core, then streams the results back out through a skid FIFO.
module fft_io
  import fft_pkg::*;
#(
  parameter int DATA_WD = -1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_val_i,
  input  logic [DATA_WD-1:0] in_dat_i,
  output logic               in_rdy_o,
  output logic               start_o,
  input  logic               done_i,
  output logic               busy_o,
  output logic [2:0]         adr_x_o,
  output logic [2:0]         adr_y_o,
  output logic               wr_val_o,
  output logic [DATA_WD-1:0] wr_dat_o,
  output logic               rd_val_o,
  input  logic               rd_val_i,
  input  logic [DATA_WD-1:0] rd_dat_i,
  output logic               out_val_o,
  output logic [DATA_WD-1:0] out_dat_o,
  output logic               out_last_o,
  input  logic               out_rdy_i
);

  localparam logic [FRAME_WD-1:0] LAST_IDX = FRAME_WD'(FRAME_LEN - 1);

  fft_io_state_t       r_state;
  fft_io_state_t       w_nextState;
  logic [FRAME_WD-1:0] r_inCnt;
  logic [FRAME_WD-1:0] r_rdCnt;
  logic [FRAME_WD-1:0] r_outCnt;
  logic                r_rdPend;
  logic                w_accept;
  logic                w_rdIssue;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [2:0]          w_occ;
  logic [2:0]          w_budget;

  assign w_accept  = (r_state == ST_LOAD) && in_val_i;
  assign w_pop     = out_val_o && out_rdy_i;
  assign w_occ     = w_full ? 3'd2 : (w_empty ? 3'd0 : 3'd1);
  // Entries the FIFO will hold once the pending read lands, net of this pop.
  assign w_budget  = w_occ + {2'b0, r_rdPend} - {2'b0, w_pop};
  assign w_rdIssue = (r_state == ST_DUMP) && (w_budget < 3'd2);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_LOAD:  if (w_accept && r_inCnt == LAST_IDX)  w_nextState = ST_STRT;
      ST_STRT:  w_nextState = ST_CALC;
      ST_CALC:  if (done_i)                           w_nextState = ST_DUMP;
      ST_DUMP:  if (w_rdIssue && r_rdCnt == LAST_IDX) w_nextState = ST_DRAIN;
      ST_DRAIN: if (w_pop && out_last_o)              w_nextState = ST_LOAD;
      default:  w_nextState = ST_LOAD;
    endcase
  end

  always_comb begin
    in_rdy_o = (r_state == ST_LOAD);
    busy_o   = (r_state != ST_LOAD);
    start_o  = (r_state == ST_STRT);
    wr_val_o = 1'b0;
    wr_dat_o = '0;
    rd_val_o = 1'b0;
    adr_x_o  = 3'd0;
    adr_y_o  = 3'd0;
    if (w_accept) begin
      wr_val_o = 1'b1;
      wr_dat_o = in_dat_i;
      adr_x_o  = r_inCnt[FRAME_WD-1:SIZE_MAT_WD];
      adr_y_o  = r_inCnt[SIZE_MAT_WD-1:0];
    end else if (w_rdIssue) begin
      rd_val_o = 1'b1;
      adr_x_o  = r_rdCnt[SIZE_MAT_WD-1:0];
      adr_y_o  = r_rdCnt[FRAME_WD-1:SIZE_MAT_WD];
    end
  end

  // Counters wrap naturally at the frame length, so each frame starts at 0.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_inCnt  <= '0;
      r_rdCnt  <= '0;
      r_outCnt <= '0;
      r_rdPend <= 1'b0;
    end else begin
      r_rdPend <= w_rdIssue;
      if (w_accept) begin
        r_inCnt <= r_inCnt + 1'b1;
      end
      if (w_rdIssue) begin
        r_rdCnt <= r_rdCnt + 1'b1;
      end
      if (w_pop) begin
        r_outCnt <= r_outCnt + 1'b1;
      end
    end
  end

  assign out_val_o  = !w_empty;
  assign out_last_o = out_val_o && (r_outCnt == LAST_IDX);

  fft_io_skid #(
    .DATA_WD (DATA_WD)
  ) u_skid (
    .clk     (clk),
    .rst     (rst_n),
    .i_push  (rd_val_i),
    .i_dat   (rd_dat_i),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dat   (out_dat_o)
  );

endmodule

// File: tb/tb_fft_io.sv
// Randomized bench for fft_io with a behavioural matrix memory and a
// frame-level reference model of the transposed load / row-major dump.
module tb_fft_io;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_val_i;
  logic [DW-1:0] in_dat_i;
  logic          in_rdy_o;
  logic          start_o;
  logic          done_i;
  logic          busy_o;
  logic [2:0]    adr_x_o;
  logic [2:0]    adr_y_o;
  logic          wr_val_o;
  logic [DW-1:0] wr_dat_o;
  logic          rd_val_o;
  logic          rd_val_i;
  logic [DW-1:0] rd_dat_i;
  logic          out_val_o;
  logic [DW-1:0] out_dat_o;
  logic          out_last_o;
  logic          out_rdy_i;

  always #5 clk = ~clk;

  fft_io #(
    .DATA_WD (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_val_i   (in_val_i),
    .in_dat_i   (in_dat_i),
    .in_rdy_o   (in_rdy_o),
    .start_o    (start_o),
    .done_i     (done_i),
    .busy_o     (busy_o),
    .adr_x_o    (adr_x_o),
    .adr_y_o    (adr_y_o),
    .wr_val_o   (wr_val_o),
    .wr_dat_o   (wr_dat_o),
    .rd_val_o   (rd_val_o),
    .rd_val_i   (rd_val_i),
    .rd_dat_i   (rd_dat_i),
    .out_val_o  (out_val_o),
    .out_dat_o  (out_dat_o),
    .out_last_o (out_last_o),
    .out_rdy_i  (out_rdy_i)
  );

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycle         = 0;

  logic [DW-1:0] mem    [64];
  logic [DW-1:0] inData [64];
  logic [DW-1:0] expOut [64];

  int  pendAddr;
  bit  tbLoading;
  int  tbPhase;
  int  lastAcceptCycle;
  int  doneCycle;
  int  firstOutCycle;
  int  firstRdCycle;
  int  lastPopCycle;
  int  popCount;
  int  wrCount;
  int  rdCount;
  int  startCount;
  bit  prevStall;
  logic [DW-1:0] prevDat;
  logic          lastWrVal;
  logic [2:0]    lastAdrX;
  logic [2:0]    lastAdrY;
  logic [DW-1:0] lastWrDat;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] expected);
    compareCount++;
    if (got !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, got, expected, cycle);
    end
  endtask

  // One clock: observe at the falling edge, then answer memory reads and
  // return just after the rising edge so the caller can drive new inputs.
  task automatic stepCycle();
    bit nextRd;
    @(negedge clk);
    cycle++;
    lastWrVal = wr_val_o;
    lastAdrX  = adr_x_o;
    lastAdrY  = adr_y_o;
    lastWrDat = wr_dat_o;
    nextRd    = 1'b0;
    if (!rst_n) begin
      checkOutput("inRdy", in_rdy_o, tbLoading);
      checkOutput("busy", busy_o, !tbLoading);
      checkOutput("wrVal", wr_val_o, in_val_i && tbLoading);
      checkOutput("start", start_o, cycle == lastAcceptCycle + 1);
      checkOutput("strobeExcl", wr_val_o && rd_val_o, 0);
      if (!wr_val_o && !rd_val_o)
        checkOutput("adrIdle", {adr_x_o, adr_y_o}, 0);
      if (tbPhase != 2)
        checkOutput("rdIdle", rd_val_o, 0);
      if (!out_val_o)
        checkOutput("lastIdle", out_last_o, 0);
      if (prevStall) begin
        checkOutput("holdVal", out_val_o, 1);
        checkOutput("holdDat", out_dat_o, prevDat);
      end
      if (wr_val_o) begin
        mem[int'(adr_y_o) * 8 + int'(adr_x_o)] = wr_dat_o;
        wrCount++;
      end
      if (start_o) startCount++;
      if (rd_val_o) begin
        pendAddr = int'(adr_y_o) * 8 + int'(adr_x_o);
        nextRd   = 1'b1;
        if (firstRdCycle < 0) firstRdCycle = cycle;
        rdCount++;
      end
      if (out_val_o && firstOutCycle < 0) firstOutCycle = cycle;
      if (out_val_o && out_rdy_i) begin
        if (popCount < 64) begin
          checkOutput("outDat", out_dat_o, expOut[popCount]);
          checkOutput("outLast", out_last_o, popCount == 63);
        end else begin
          checkOutput("extraPop", popCount, 63);
        end
        popCount++;
        lastPopCycle = cycle;
        if (popCount == 64) begin
          tbLoading = 1'b1;
          tbPhase   = 0;
        end
      end
      prevStall = out_val_o && !out_rdy_i;
      prevDat   = out_dat_o;
    end else begin
      prevStall = 1'b0;
    end
    @(posedge clk);
    #1;
    rd_val_i = nextRd;
    rd_dat_i = nextRd ? mem[pendAddr] : DW'($urandom);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".inRdy"},   in_rdy_o, 1);
    checkOutput({tag, ".busy"},    busy_o, 0);
    checkOutput({tag, ".start"},   start_o, 0);
    checkOutput({tag, ".wrVal"},   wr_val_o, 0);
    checkOutput({tag, ".wrDat"},   wr_dat_o, 0);
    checkOutput({tag, ".rdVal"},   rd_val_o, 0);
    checkOutput({tag, ".adrX"},    adr_x_o, 0);
    checkOutput({tag, ".adrY"},    adr_y_o, 0);
    checkOutput({tag, ".outVal"},  out_val_o, 0);
    checkOutput({tag, ".outDat"},  out_dat_o, 0);
    checkOutput({tag, ".outLast"}, out_last_o, 0);
  endtask

  task automatic doReset();
    in_val_i        = 1'b0;
    done_i          = 1'b0;
    out_rdy_i       = 1'b0;
    rst_n           = 1'b1;
    tbLoading       = 1'b1;
    tbPhase         = 0;
    prevStall       = 1'b0;
    lastAcceptCycle = -10;
    repeat (3) stepCycle();
    checkResetValues("inReset");
    rst_n = 1'b0;
    stepCycle();
    checkResetValues("afterReset");
  endtask

  // Load one frame, let the core "compute", then drain all results.
  task automatic applyStimulus(input bit prefill, input bit randReady,
                               input bit gaps, input int abortAt);
    int n = 0;
    int budget = 0;
    popCount      = 0;
    wrCount       = 0;
    rdCount       = 0;
    startCount    = 0;
    firstOutCycle = -1;
    firstRdCycle  = -1;
    for (int i = 0; i < 64; i++) inData[i] = DW'($urandom);
    while (n < 64 && budget < 500) begin
      budget++;
      out_rdy_i = 1'($urandom_range(0, 1));
      done_i    = ($urandom_range(0, 7) == 0);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_val_i = 1'b0;
        in_dat_i = DW'($urandom);
        stepCycle();
        checkOutput("gapNoWr", lastWrVal, 0);
      end else begin
        in_val_i = 1'b1;
        in_dat_i = inData[n];
        stepCycle();
        checkOutput("ldWr", lastWrVal, 1);
        checkOutput("ldDat", lastWrDat, inData[n]);
        checkOutput("ldAdrX", lastAdrX, n / 8);
        checkOutput("ldAdrY", lastAdrY, n % 8);
        n++;
        if (n == 64) begin
          lastAcceptCycle = cycle;
          tbLoading       = 1'b0;
          tbPhase         = 1;
        end
      end
    end
    checkOutput("loadCount", n, 64);
    done_i = 1'b0;
    repeat ($urandom_range(2, 6)) begin
      in_val_i = 1'($urandom_range(0, 1));
      in_dat_i = DW'($urandom);
      stepCycle();
    end
    checkOutput("startOnce", startCount, 1);
    checkOutput("wrCount", wrCount, 64);
    if (prefill) begin
      for (int a = 0; a < 64; a++) mem[a] = DW'(16'hA000 + a);
      for (int k = 0; k < 64; k++) expOut[k] = DW'(16'hA000 + k);
    end else begin
      for (int k = 0; k < 64; k++) expOut[k] = inData[(k % 8) * 8 + k / 8];
    end
    done_i   = 1'b1;
    in_val_i = 1'b0;
    stepCycle();
    doneCycle = cycle;
    tbPhase   = 2;
    done_i    = 1'b0;
    budget    = 0;
    while (popCount < 64 && budget < 1000) begin
      if (abortAt >= 0 && popCount == abortAt) break;
      out_rdy_i = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      in_val_i  = 1'($urandom_range(0, 1));
      in_dat_i  = DW'($urandom);
      done_i    = ($urandom_range(0, 7) == 0);
      stepCycle();
      budget++;
    end
    in_val_i = 1'b0;
    done_i   = 1'b0;
    if (abortAt >= 0) begin
      checkOutput("abortPops", popCount, abortAt);
    end else begin
      checkOutput("popCount", popCount, 64);
      checkOutput("rdCount", rdCount, 64);
      checkOutput("wrTotal", wrCount, 64);
      if (!randReady) begin
        checkOutput("firstRd", firstRdCycle, doneCycle + 1);
        checkOutput("firstOut", firstOutCycle, doneCycle + 3);
        checkOutput("lastPop", lastPopCycle, doneCycle + 66);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    in_val_i  = 1'b0;
    in_dat_i  = '0;
    done_i    = 1'b0;
    out_rdy_i = 1'b0;
    rd_val_i  = 1'b0;
    rd_dat_i  = '0;
    pendAddr  = 0;
    for (int a = 0; a < 64; a++) mem[a] = '0;

    doReset();

    done_i = 1'b1;
    stepCycle();
    done_i = 1'b0;
    repeat (2) stepCycle();
    checkOutput("doneInLoad", busy_o, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, -1);
    applyStimulus(1'b0, 1'b0, 1'b0, -1);
    applyStimulus(1'b0, 1'b1, 1'b1, -1);
    applyStimulus(1'b0, 1'b1, 1'b1, -1);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, -1);
    applyStimulus(1'b0, 1'b0, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
